// File: rtl/ctrl_types_pkg.sv
// Shared types for the cache operation controller: operation/status encodings
// and controller states.
package ctrl_types_pkg;

    typedef enum logic [2:0] {
        OP_NOOP   = 3'd0,
        OP_READ   = 3'd1,
        OP_CREATE = 3'd2,
        OP_UPDATE = 3'd3,
        OP_DELETE = 3'd4
    } operation_e;

    typedef enum logic [2:0] {
        ST_OK,
        ST_MISS,
        ST_EXISTS,
        ST_FULL,
        ST_ERROR
    } status_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_EXEC,
        ST_RESP
    } ctrl_state_e;

    // Encodings 5..7 are unassigned and answer with ERROR.
    function automatic logic is_known_op(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/free_slot_finder.sv
// Lowest-index free slot: one-hot of the first zero in used_in, plus a full flag.
module free_slot_finder #(
    parameter int NUM_ENTRIES = 16
) (
    input  logic [NUM_ENTRIES-1:0] used_in,
    output logic [NUM_ENTRIES-1:0] slot_out,
    output logic                   full_out
);

    always_comb begin
        logic found;
        found    = 1'b0;
        slot_out = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!used_in[i] && !found) begin
                slot_out[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign full_out = &used_in;

endmodule

// File: rtl/cache_op_controller.sv
// Cache operation controller: request handshake, multi-cycle key lookup,
// a single memory strobe, then a held status response.
module cache_op_controller
    import ctrl_types_pkg::*;
#(
    parameter int NUM_ENTRIES    = 16,
    parameter int LOOKUP_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   op_valid_in,
    output logic                   op_ready_out,
    input  operation_e             operation_in,
    input  logic [NUM_ENTRIES-1:0] used_in,
    input  logic                   hit_in,
    input  logic [NUM_ENTRIES-1:0] hit_idx_in,
    output logic                   lookup_out,
    output logic [NUM_ENTRIES-1:0] idx_out,
    output logic                   select_out,
    output logic                   write_out,
    output logic                   delete_out,
    output logic                   resp_valid_out,
    input  logic                   resp_ready_in,
    output status_e                resp_status_out
);

    localparam int CNT_W = $clog2(LOOKUP_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOOKUP_LATENCY - 1);

    ctrl_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    operation_e             op_q, op_d;
    status_e                pend_q, pend_d;
    status_e                status_q, status_d;
    logic [NUM_ENTRIES-1:0] idx_q, idx_d;
    logic                   sel_q, sel_d;
    logic                   wr_q, wr_d;
    logic                   del_q, del_d;
    logic                   lookup_q, lookup_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   op_ready_q, op_ready_d;

    logic [NUM_ENTRIES-1:0] free_slot;
    logic                   all_used;

    free_slot_finder #(.NUM_ENTRIES(NUM_ENTRIES)) u_free_slot (
        .used_in  (used_in),
        .slot_out (free_slot),
        .full_out (all_used)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        pend_d       = pend_q;
        status_d     = status_q;
        resp_valid_d = resp_valid_q;
        idx_d        = '0;
        sel_d        = 1'b0;
        wr_d         = 1'b0;
        del_d        = 1'b0;
        lookup_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_valid_in) begin
                    if (!is_known_op(operation_in)) begin
                        status_d     = ST_ERROR;
                        resp_valid_d = 1'b1;
                        state_d      = ST_RESP;
                    end else if (operation_in != OP_NOOP) begin
                        op_d     = operation_in;
                        cnt_d    = '0;
                        lookup_d = 1'b1;
                        state_d  = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                lookup_d = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // The action is resolved as the memory result is sampled,
                    // so every EXEC-cycle output comes straight from a flop.
                    lookup_d = 1'b0;
                    state_d  = ST_EXEC;
                    pend_d   = ST_OK;
                    if (hit_in && $countones(hit_idx_in) != 1) begin
                        pend_d = ST_ERROR;
                    end else if (hit_in) begin
                        case (op_q)
                            OP_READ:   begin sel_d = 1'b1; idx_d = hit_idx_in; end
                            OP_UPDATE: begin wr_d  = 1'b1; idx_d = hit_idx_in; end
                            OP_DELETE: begin del_d = 1'b1; idx_d = hit_idx_in; end
                            OP_CREATE: pend_d = ST_EXISTS;
                            default:   pend_d = ST_ERROR;
                        endcase
                    end else if (op_q == OP_CREATE) begin
                        if (all_used) begin
                            pend_d = ST_FULL;
                        end else begin
                            wr_d  = 1'b1;
                            idx_d = free_slot;
                        end
                    end else begin
                        pend_d = ST_MISS;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EXEC: begin
                status_d     = pend_q;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready_in) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        op_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_q         <= OP_NOOP;
            pend_q       <= ST_OK;
            status_q     <= ST_OK;
            idx_q        <= '0;
            sel_q        <= 1'b0;
            wr_q         <= 1'b0;
            del_q        <= 1'b0;
            lookup_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            op_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            pend_q       <= pend_d;
            status_q     <= status_d;
            idx_q        <= idx_d;
            sel_q        <= sel_d;
            wr_q         <= wr_d;
            del_q        <= del_d;
            lookup_q     <= lookup_d;
            resp_valid_q <= resp_valid_d;
            op_ready_q   <= op_ready_d;
        end
    end

    assign op_ready_out    = op_ready_q;
    assign lookup_out      = lookup_q;
    assign idx_out         = idx_q;
    assign select_out      = sel_q;
    assign write_out       = wr_q;
    assign delete_out      = del_q;
    assign resp_valid_out  = resp_valid_q;
    assign resp_status_out = status_q;

endmodule

// File: tb/tb_cache_op_controller.sv
// Bench for cache_op_controller: two instances (lookup latency 1 and 3) driven
// by directed and random operations against a behavioural model.
module tb_cache_op_controller;
    import ctrl_types_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n[2];
    logic         op_valid[2];
    operation_e   op[2];
    logic [N-1:0] used[2];
    logic         hit[2];
    logic [N-1:0] hidx[2];
    logic         resp_ready[2];
    logic         op_ready[2];
    logic         lookup[2];
    logic         sel[2];
    logic         wr[2];
    logic         del[2];
    logic         resp_valid[2];
    logic [N-1:0] idx[2];
    status_e      status[2];

    int checks   = 0;
    int failures = 0;

    cache_op_controller #(.NUM_ENTRIES(N), .LOOKUP_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n[0]), .op_valid_in(op_valid[0]), .op_ready_out(op_ready[0]),
        .operation_in(op[0]), .used_in(used[0]), .hit_in(hit[0]), .hit_idx_in(hidx[0]),
        .lookup_out(lookup[0]), .idx_out(idx[0]), .select_out(sel[0]), .write_out(wr[0]),
        .delete_out(del[0]), .resp_valid_out(resp_valid[0]), .resp_ready_in(resp_ready[0]),
        .resp_status_out(status[0])
    );

    cache_op_controller #(.NUM_ENTRIES(N), .LOOKUP_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n[1]), .op_valid_in(op_valid[1]), .op_ready_out(op_ready[1]),
        .operation_in(op[1]), .used_in(used[1]), .hit_in(hit[1]), .hit_idx_in(hidx[1]),
        .lookup_out(lookup[1]), .idx_out(idx[1]), .select_out(sel[1]), .write_out(wr[1]),
        .delete_out(del[1]), .resp_valid_out(resp_valid[1]), .resp_ready_in(resp_ready[1]),
        .resp_status_out(status[1])
    );

    function automatic int lat(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected strobe (bit0 select, bit1 write, bit2 delete), index and status.
    function automatic void model(input logic [2:0] opc, input logic h, input logic [N-1:0] hi,
                                  input logic [N-1:0] us, output logic [2:0] stb,
                                  output logic [N-1:0] ix, output status_e st);
        int z;
        stb = 3'b000;
        ix  = '0;
        st  = ST_OK;
        z   = N;
        if (h && $countones(hi) != 1) begin
            st = ST_ERROR;
        end else begin
            case (opc)
                3'd1, 3'd3, 3'd4: begin
                    if (h) begin
                        stb = (opc == 3'd1) ? 3'b001 : (opc == 3'd3) ? 3'b010 : 3'b100;
                        ix  = hi;
                    end else begin
                        st = ST_MISS;
                    end
                end
                3'd2: begin
                    if (h) st = ST_EXISTS;
                    else if (us == {N{1'b1}}) st = ST_FULL;
                    else begin
                        for (int i = N - 1; i >= 0; i--) if (!us[i]) z = i;
                        ix[z] = 1'b1;
                        stb   = 3'b010;
                    end
                end
                default: st = ST_ERROR;
            endcase
        end
    endfunction

    task automatic chk_idle_zero(input int u);
        chk("rst_lookup", lookup[u], 0);
        chk("rst_strobes", {del[u], wr[u], sel[u]}, 0);
        chk("rst_idx", idx[u], 0);
        chk("rst_resp_valid", resp_valid[u], 0);
        chk("rst_op_ready", op_ready[u], 1);
        chk("rst_status", status[u], ST_OK);
    endtask

    task automatic wait_ready(input int u);
        int n;
        n = 0;
        while (!op_ready[u] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", op_ready[u], 1);
    endtask

    task automatic do_op(input int u, input logic [2:0] opc, input logic h,
                         input logic [N-1:0] hi, input logic [N-1:0] us, input int hold);
        logic [2:0]   estb;
        logic [N-1:0] eidx;
        status_e      est;
        model(opc, h, hi, us, estb, eidx, est);
        wait_ready(u);
        // Inputs carry the inverse of the real result except on the final lookup cycle.
        op_valid[u]   = 1'b1;
        op[u]         = operation_e'(opc);
        hit[u]        = ~h;
        hidx[u]       = ~hi;
        used[u]       = ~us;
        resp_ready[u] = 1'b1;
        @(negedge clk);
        op_valid[u] = 1'b0;
        if (opc == 3'd0) begin
            chk("noop_ready", op_ready[u], 1);
            chk("noop_lookup", lookup[u], 0);
            chk("noop_valid", resp_valid[u], 0);
            return;
        end
        if (opc <= 3'd4) begin
            for (int k = 1; k <= lat(u); k++) begin
                chk("lookup_high", lookup[u], 1);
                chk("lookup_no_strobe", {del[u], wr[u], sel[u]}, 0);
                chk("lookup_no_valid", resp_valid[u], 0);
                if (k == lat(u)) begin
                    hit[u]  = h;
                    hidx[u] = hi;
                    used[u] = us;
                end
                @(negedge clk);
            end
            hit[u]  = ~h;
            hidx[u] = ~hi;
            used[u] = ~us;
            chk("exec_lookup_low", lookup[u], 0);
            chk("exec_strobe", {del[u], wr[u], sel[u]}, estb);
            chk("exec_idx", idx[u], eidx);
            chk("exec_valid_low", resp_valid[u], 0);
            @(negedge clk);
        end
        for (int h2 = 0; h2 <= hold; h2++) begin
            chk("resp_valid", resp_valid[u], 1);
            chk("resp_status", status[u], est);
            chk("resp_op_ready_low", op_ready[u], 0);
            chk("resp_no_strobe", {del[u], wr[u], sel[u]}, 0);
            chk("resp_lookup_low", lookup[u], 0);
            resp_ready[u] = (h2 == hold);
            op_valid[u]   = (h2 != hold);
            op[u]         = OP_READ;
            @(negedge clk);
        end
        op_valid[u]   = 1'b0;
        resp_ready[u] = 1'b0;
        chk("post_op_ready", op_ready[u], 1);
        chk("post_valid_low", resp_valid[u], 0);
        chk("post_status_held", status[u], est);
    endtask

    task automatic quiet_after_reset(input int u);
        for (int k = 0; k < lat(u) + 3; k++) begin
            @(negedge clk);
            chk("after_rst_no_strobe", {del[u], wr[u], sel[u]}, 0);
            chk("after_rst_lookup", lookup[u], 0);
            chk("after_rst_ready", op_ready[u], 1);
            chk("after_rst_valid", resp_valid[u], 0);
        end
    endtask

    task automatic reset_in_lookup(input int u);
        wait_ready(u);
        op_valid[u] = 1'b1;
        op[u]       = OP_READ;
        hit[u]      = 1'b1;
        hidx[u]     = 4'b0001;
        used[u]     = '1;
        @(negedge clk);
        op_valid[u] = 1'b0;
        chk("pre_rst_lookup", lookup[u], 1);
        rst_n[u] = 1'b0;
        #1;
        chk_idle_zero(u);
        @(negedge clk);
        rst_n[u] = 1'b1;
        quiet_after_reset(u);
    endtask

    task automatic reset_in_resp(input int u);
        wait_ready(u);
        op_valid[u]   = 1'b1;
        op[u]         = OP_DELETE;
        hit[u]        = 1'b0;
        hidx[u]       = '0;
        resp_ready[u] = 1'b0;
        @(negedge clk);
        op_valid[u] = 1'b0;
        repeat (lat(u) + 1) @(negedge clk);
        chk("pre_rst_valid", resp_valid[u], 1);
        chk("pre_rst_status", status[u], ST_MISS);
        hit[u]  = 1'b1;
        hidx[u] = 4'b0010;
        rst_n[u] = 1'b0;
        #1;
        chk_idle_zero(u);
        @(negedge clk);
        rst_n[u] = 1'b1;
        quiet_after_reset(u);
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            chk("inv_one_strobe", (int'(sel[u]) + int'(wr[u]) + int'(del[u])) <= 1, 1);
            chk("inv_idx_zero", (sel[u] | wr[u] | del[u]) || (idx[u] == '0), 1);
            chk("inv_ready_vs_valid", !(op_ready[u] && resp_valid[u]), 1);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; op_valid[u] = 1'b0; op[u] = OP_NOOP; used[u] = '0;
            hit[u] = 1'b0; hidx[u] = '0; resp_ready[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) chk_idle_zero(u);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) chk_idle_zero(u);

        do_op(0, 3'd1, 1'b1, 4'b0100, 4'b1111, 0);
        do_op(0, 3'd2, 1'b0, 4'b0000, 4'b1011, 0);
        do_op(0, 3'd2, 1'b0, 4'b0000, 4'b1111, 0);
        do_op(0, 3'd2, 1'b1, 4'b0001, 4'b1011, 0);
        do_op(0, 3'd4, 1'b0, 4'b0000, 4'b0101, 0);
        do_op(0, 3'd3, 1'b1, 4'b0110, 4'b1111, 0);
        do_op(0, 3'd1, 1'b1, 4'b1000, 4'b1000, 5);
        do_op(0, 3'd6, 1'b1, 4'b0001, 4'b0000, 1);
        do_op(0, 3'd0, 1'b1, 4'b0001, 4'b0000, 0);
        do_op(1, 3'd1, 1'b0, 4'b0010, 4'b1111, 0);
        do_op(1, 3'd3, 1'b1, 4'b0010, 4'b1111, 2);
        do_op(1, 3'd4, 1'b1, 4'b1000, 4'b1111, 0);
        do_op(1, 3'd2, 1'b0, 4'b0000, 4'b0111, 0);
        do_op(1, 3'd2, 1'b0, 4'b0000, 4'b0000, 5);

        reset_in_lookup(0);
        reset_in_resp(0);
        reset_in_lookup(1);
        reset_in_resp(1);

        for (int i = 0; i < 80; i++) begin
            int           u, r, hold;
            logic [2:0]   opc;
            logic         h;
            logic [N-1:0] hi, us;
            u    = i % 2;
            r    = $urandom_range(0, 11);
            opc  = (r < 10) ? 3'(r % 5) : 3'(5 + r % 3);
            h    = 1'($urandom_range(0, 1));
            hi   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            us   = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
            hold = $urandom_range(0, 3);
            do_op(u, opc, h, hi, us, hold);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_op_controller.md
Name: cache_op_controller

Overview:
- Parametrised successor to the single-cycle CRUD controller: accepts one cache operation per valid/ready handshake and waits a configurable lookup latency for the memory hit result.
- Issues exactly one memory strobe (select/write/delete) with a one-hot index, then returns a held status response through a second valid/ready handshake.
- Sits between the host interface and the key/value memory array.

Parameters:
- NUM_ENTRIES, 16, number of cache slots; width of used/hit/idx vectors (>=2).
- LOOKUP_LATENCY, 1, cycles from lookup_out assertion until hit_in/hit_idx_in are valid (>=1).
- CNT_W, $clog2(LOOKUP_LATENCY+1), lookup counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid_in  in  1  operation request valid.
- op_ready_out  out  1  controller can accept a request (high only in ST_IDLE).
- operation_in  in  operation_e  NOOP/READ/CREATE/UPDATE/DELETE.
- used_in  in  NUM_ENTRIES  slot occupancy from memory.
- hit_in  in  1  key match found (valid on last lookup cycle).
- hit_idx_in  in  NUM_ENTRIES  one-hot matching slot.
- lookup_out  out  1  request memory key compare.
- idx_out  out  NUM_ENTRIES  one-hot target slot, nonzero only with a strobe.
- select_out  out  1  read strobe.
- write_out  out  1  write strobe.
- delete_out  out  1  delete strobe.
- resp_valid_out  out  1  response valid.
- resp_ready_in  in  1  response consumed.
- resp_status_out  out  status_e  OK/MISS/EXISTS/FULL/ERROR.

Behaviour:
- Reset (async, any state): state=ST_IDLE, counter=0, all strobes/idx_out/lookup_out/resp_valid_out=0, resp_status_out=OK, op_ready_out=1 after reset.
- Reset during an operation aborts it: no strobe is issued afterwards.
- ST_IDLE:
  - op_ready_out=1.
  - On op_valid_in && operation_in!=NOOP, latch the op and go to ST_LOOKUP.
  - NOOP is consumed silently.
  - An unlisted encoding latches as ERROR and goes directly to ST_RESP.
- ST_LOOKUP:
  - lookup_out=1; the counter runs 0..LOOKUP_LATENCY-1.
  - On the final count, register hit_in, hit_idx_in and used_in, then go to ST_EXEC.
- ST_EXEC (exactly 1 cycle): decide the action from the registered values; strobes are asserted only in this cycle.
  - Onehot check: hit with popcount(hit_idx)!=1 -> ERROR, no strobe.
  - READ: hit -> select_out=1, idx_out=hit_idx, OK. Miss -> MISS.
  - UPDATE: hit -> write_out=1, idx_out=hit_idx, OK. Miss -> MISS.
  - DELETE: hit -> delete_out=1, idx_out=hit_idx, OK. Miss -> MISS.
  - CREATE, hit -> EXISTS, no strobe.
  - CREATE, used all ones -> FULL, no strobe.
  - CREATE, otherwise -> write_out=1, idx_out=lowest-index zero bit of used, OK.
- ST_RESP:
  - resp_valid_out=1; resp_status_out is held stable until resp_valid_out && resp_ready_in.
  - On that handshake, return to ST_IDLE in the next cycle.
  - resp_ready_in is ignored outside ST_RESP.
- Latency from accept at cycle T:
  - lookup T+1..T+L.
  - Strobe at T+L+1.
  - resp_valid from T+L+2.
  - Next accept at the earliest T+L+3.
- Status hold:
  - resp_status_out keeps its last value outside ST_RESP.
  - It updates at the ST_EXEC->ST_RESP edge.
- Input sampling:
  - used_in and hit inputs are sampled only on the last lookup cycle.
  - Changes after sampling do not affect the current operation.
- At most one strobe is high in any cycle.
- Assertions:
  - idx_out == 0 whenever no strobe is high.
  - op_ready_out && resp_valid_out is never true.

Decomposition:
- ctrl_types_pkg additions:
  - operation_e (keep existing encodings).
  - status_e {ST_OK, ST_MISS, ST_EXISTS, ST_FULL, ST_ERROR}.
  - ctrl_state_e {ST_IDLE, ST_LOOKUP, ST_EXEC, ST_RESP}.
- Sub-module free_slot_finder #(NUM_ENTRIES): combinational lowest-zero priority encoder producing a one-hot output plus a full flag; instantiated once.

Test Plan:
- NUM_ENTRIES=4, L=1. READ, hit_idx=4'b0100 on lookup cycle -> T+2: select_out=1, idx_out=4'b0100. T+3: resp_valid, status OK.
- CREATE, used=4'b1011, hit=0 -> write_out=1, idx_out=4'b0100, OK. Repeat with used=4'b1111 -> no strobe, FULL. Repeat with hit=1 -> EXISTS.
- DELETE miss -> no strobe, MISS. UPDATE with hit=1, hit_idx=4'b0110 -> ERROR, no strobe.
- L=3: lookup_out high exactly 3 cycles. hit asserted only in cycle 2 of lookup -> treated as miss. Strobe at T+4.
- Hold resp_ready_in=0 for 5 cycles -> resp_valid_out and status stable, op_ready_out=0, a new op_valid_in is ignored. Ready=1 -> IDLE next cycle.
- Assert rst_n=0 in ST_LOOKUP and again in ST_RESP -> outputs zero immediately, no strobe after release, op_ready_out=1.
